// File: rtl/kp_scan_ctrl_if.sv
// Keypad-side and downstream-side signals of the keypad scan controller.
// The master modport is the controller itself; slave is the keypad/consumer side.
interface kp_scan_ctrl_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  logic            en;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_drv;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            load;

  modport master (
    input  en, row_in,
    output col_drv, key_code, key_valid, key_held, load
  );

  modport slave (
    output en, row_in,
    input  col_drv, key_code, key_valid, key_held, load
  );
endinterface

// File: rtl/kp_scan_ctrl.sv
// Matrix keypad scanner: walks one-cold column drive, samples active-low rows,
// debounces press and release, and reports key index with press/release pulses.
module kp_scan_ctrl #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  kp_scan_ctrl_if.master kp
);
  localparam int CW   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CNTW = $clog2(DEBOUNCE + 1);

  localparam logic [2:0] S_SCAN     = 3'd0;
  localparam logic [2:0] S_PRESS_DB = 3'd1;
  localparam logic [2:0] S_PRESSED  = 3'd2;
  localparam logic [2:0] S_REL_DB   = 3'd3;
  localparam logic [2:0] S_RELEASED = 3'd4;

  logic [2:0]      state_reg, state_next;
  logic [CIW-1:0]  c_reg, c_next, c_inc;
  logic [DW-1:0]   dwell_reg, dwell_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic [RIW-1:0]  r_reg, r_next;
  logic [CW-1:0]   code_reg, code_next;
  logic            valid_reg, valid_next;
  logic            held_reg, held_next;
  logic            load_reg, load_next;

  logic [RIW-1:0]  low_idx;
  logic            any_low;
  logic            row_sel;
  logic            drive_on;

  function automatic logic [CW-1:0] code_of(input logic [CIW-1:0] col, input logic [RIW-1:0] row);
    return CW'(int'(col) * ROWS + int'(row));
  endfunction

  // Lowest-index closed row wins when several keys share the driven column.
  always_comb begin
    low_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!kp.row_in[i]) low_idx = RIW'(i);
    end
  end

  assign any_low = ~&kp.row_in;
  assign row_sel = kp.row_in[r_reg];
  assign c_inc   = (c_reg == CIW'(COLS - 1)) ? '0 : c_reg + 1'b1;

  // Columns float high only while scanning is paused; debounce keeps its column driven.
  assign drive_on = (state_reg != S_SCAN) || kp.en;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign kp.col_drv[gi] = ~(drive_on && (c_reg == CIW'(gi)));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    dwell_next = dwell_reg;
    cnt_next   = cnt_reg;
    r_next     = r_reg;
    code_next  = code_reg;
    valid_next = 1'b0;
    held_next  = held_reg;
    load_next  = 1'b0;
    case (state_reg)
      S_SCAN: begin
        if (kp.en) begin
          if (dwell_reg == DW'(SETTLE - 1)) begin
            dwell_next = '0;
            if (any_low) begin
              r_next   = low_idx;
              cnt_next = CNTW'(1);
              // The scan sample is the first debounce sample, so DEBOUNCE=1 accepts here.
              if (DEBOUNCE == 1) begin
                state_next = S_PRESSED;
                valid_next = 1'b1;
                held_next  = 1'b1;
                code_next  = code_of(c_reg, low_idx);
              end else begin
                state_next = S_PRESS_DB;
              end
            end else begin
              c_next = c_inc;
            end
          end else begin
            dwell_next = dwell_reg + 1'b1;
          end
        end
      end
      S_PRESS_DB: begin
        if (!row_sel) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNTW'(DEBOUNCE - 1)) begin
            state_next = S_PRESSED;
            valid_next = 1'b1;
            held_next  = 1'b1;
            code_next  = code_of(c_reg, r_reg);
          end
        end else begin
          state_next = S_SCAN;
          c_next     = c_inc;
          dwell_next = '0;
        end
      end
      S_PRESSED: begin
        if (row_sel) begin
          cnt_next = CNTW'(1);
          if (DEBOUNCE == 1) begin
            state_next = S_RELEASED;
            load_next  = 1'b1;
            held_next  = 1'b0;
          end else begin
            state_next = S_REL_DB;
          end
        end
      end
      S_REL_DB: begin
        if (row_sel) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNTW'(DEBOUNCE - 1)) begin
            state_next = S_RELEASED;
            load_next  = 1'b1;
            held_next  = 1'b0;
          end
        end else begin
          state_next = S_PRESSED;
        end
      end
      S_RELEASED: begin
        state_next = S_SCAN;
        c_next     = c_inc;
        dwell_next = '0;
      end
      default: begin
        state_next = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_SCAN;
      c_reg     <= '0;
      dwell_reg <= '0;
      cnt_reg   <= '0;
      r_reg     <= '0;
      code_reg  <= '0;
      valid_reg <= 1'b0;
      held_reg  <= 1'b0;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      dwell_reg <= dwell_next;
      cnt_reg   <= cnt_next;
      r_reg     <= r_next;
      code_reg  <= code_next;
      valid_reg <= valid_next;
      held_reg  <= held_next;
      load_reg  <= load_next;
    end
  end

  assign kp.key_code  = code_reg;
  assign kp.key_valid = valid_reg;
  assign kp.key_held  = held_reg;
  assign kp.load      = load_reg;

endmodule

// File: tb/tb_kp_scan_ctrl.sv
// Bench for kp_scan_ctrl: a keypad model closes rows on driven columns and a
// scoreboard of expected press/release pulses is checked by a cycle monitor.
module tb_kp_scan_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef struct {
    bit is_load;
    int code;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic [ROWS*COLS-1:0] keys;
  ev_t  exp_q[$];

  kp_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  kp_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .SETTLE(2), .DEBOUNCE(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is the period after the n-th rising edge since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Passive keypad: a closed key pulls its row low only while its column is driven.
  always_comb begin
    bus.row_in = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (keys[c*ROWS+r] && !bus.col_drv[c]) bus.row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.key_valid && bus.load) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_overlap: cycle %0d key_valid=1 load=1, required not both", cyc);
      end
      if (bus.key_valid || bus.load) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: cycle %0d key_valid=%0b load=%0b code=%0d, none expected",
                   cyc, bus.key_valid, bus.load, bus.key_code);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          n_checks++;
          if (bus.load !== ev.is_load) begin
            n_fail++;
            $display("FAIL pulse_kind: cycle %0d load=%0b, required load=%0b", cyc, bus.load, ev.is_load);
          end
          n_checks++;
          if (int'(bus.key_code) != ev.code) begin
            n_fail++;
            $display("FAIL pulse_code: cycle %0d key_code=%0d, required %0d", cyc, bus.key_code, ev.code);
          end
          n_checks++;
          if (cyc != ev.cyc) begin
            n_fail++;
            $display("FAIL pulse_cycle: pulse at cycle %0d, required cycle %0d", cyc, ev.cyc);
          end
        end
      end
    end
  end

  function automatic void push_ev(input bit is_load, input int code, input int at);
    ev_t ev;
    ev.is_load = is_load;
    ev.code    = code;
    ev.cyc     = at;
    exp_q.push_back(ev);
  endfunction

  task automatic to_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Leaves the bench at the falling edge that opens cycle 0.
  task automatic do_reset(input logic [ROWS*COLS-1:0] k);
    @(negedge clk);
    rst_n = 1'b0;
    keys  = k;
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_drain(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d expected pulses not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_cols(input string name, input logic [COLS-1:0] req);
    n_checks++;
    if (bus.col_drv !== req) begin
      n_fail++;
      $display("FAIL %s: cycle %0d col_drv=%b, required %b", name, cyc, bus.col_drv, req);
    end
  endtask

  task automatic check_held(input string name, input logic req);
    n_checks++;
    if (bus.key_held !== req) begin
      n_fail++;
      $display("FAIL %s: cycle %0d key_held=%b, required %b", name, cyc, bus.key_held, req);
    end
  endtask

  task automatic check_code(input string name, input int req);
    n_checks++;
    if (int'(bus.key_code) != req) begin
      n_fail++;
      $display("FAIL %s: cycle %0d key_code=%0d, required %0d", name, cyc, bus.key_code, req);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    keys = '0;
    bus.en = 1'b0;
    #1 check_cols("reset_en0_cols", 4'b1111);
    bus.en = 1'b1;
    #1 check_cols("reset_en1_cols", 4'b1110);
    check_code("reset_code", 0);
    check_held("reset_held", 1'b0);
    n_checks++;
    if (bus.key_valid !== 1'b0 || bus.load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: key_valid=%b load=%b, required 0 0", bus.key_valid, bus.load);
    end
    do_reset('0);
    check_cols("reset_cycle0_cols", 4'b1110);
    to_cycle(2);
    check_cols("scan_col1_cycle2", 4'b1101);
    to_cycle(6);
    check_cols("scan_col3_cycle6", 4'b0111);
    to_cycle(8);
    check_cols("scan_wrap_cycle8", 4'b1110);
    $display("test_reset done, cycle %0d", cyc);
  endtask

  task automatic test_press_release();
    do_reset(16'h0040);          // key 6: col 1, row 2, sampled at cycle 3
    push_ev(1'b0, 6, 7);
    to_cycle(8);
    check_held("basic_held", 1'b1);
    check_code("basic_code", 6);
    to_cycle(10);
    keys = '0;                   // first high sample at cycle 10
    push_ev(1'b1, 6, 14);
    to_cycle(13);
    check_held("basic_held_reldb", 1'b1);
    to_cycle(14);
    check_held("basic_held_fall", 1'b0);
    check_code("basic_code_after_release", 6);
    to_cycle(15);
    check_cols("basic_resume_col2", 4'b1011);
    to_cycle(16);
    check_drain("basic");
    $display("test_press_release done, key_code=%0d", bus.key_code);
  endtask

  task automatic test_press_bounce();
    do_reset(16'h0100);          // key 8: col 2, row 0, sampled at cycle 5
    to_cycle(6);
    keys = '0;
    to_cycle(7);
    check_cols("pbounce_next_col3", 4'b0111);
    to_cycle(9);
    check_cols("pbounce_wrap_col0", 4'b1110);
    check_code("pbounce_code", 0);
    check_held("pbounce_held", 1'b0);
    check_drain("pbounce");
    $display("test_press_bounce done, key_code=%0d", bus.key_code);
  endtask

  task automatic test_release_bounce();
    do_reset(16'h0040);
    push_ev(1'b0, 6, 7);
    to_cycle(9);
    keys = '0;                   // high samples at cycles 9 and 10
    to_cycle(11);
    keys = 16'h0040;             // low again at cycle 11
    check_held("rbounce_held_11", 1'b1);
    to_cycle(13);
    check_held("rbounce_held_13", 1'b1);
    to_cycle(14);
    keys = '0;
    push_ev(1'b1, 6, 18);
    to_cycle(19);
    check_held("rbounce_held_end", 1'b0);
    check_drain("rbounce");
    $display("test_release_bounce done, key_code=%0d", bus.key_code);
  endtask

  task automatic test_two_keys();
    do_reset(16'h000A);          // keys 1 and 3 on column 0
    push_ev(1'b0, 1, 5);
    to_cycle(7);
    keys = '0;
    push_ev(1'b1, 1, 11);
    to_cycle(12);
    check_code("twokeys_code", 1);
    check_drain("twokeys");
    $display("test_two_keys done, key_code=%0d", bus.key_code);
  endtask

  task automatic test_wrap();
    do_reset(16'h8000);          // key 15: col 3, row 3, sampled at cycle 7
    push_ev(1'b0, 15, 11);
    to_cycle(13);
    keys = '0;
    push_ev(1'b1, 15, 17);
    to_cycle(18);
    check_cols("wrap_col0_after_load", 4'b1110);
    check_drain("wrap");
    $display("test_wrap done, key_code=%0d", bus.key_code);
  endtask

  task automatic test_enable();
    do_reset(16'h0010);          // key 4: col 1, row 0
    to_cycle(2);
    bus.en = 1'b0;
    #1 check_cols("en0_cols_start", 4'b1111);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_cols("en0_cols", 4'b1111);
    end
    bus.en = 1'b1;               // frozen at c=1, dwell=0 for edges of cycles 2..11
    #1 check_cols("en1_resume_col1", 4'b1101);
    push_ev(1'b0, 4, 17);
    to_cycle(19);
    keys = '0;
    push_ev(1'b1, 4, 23);
    to_cycle(24);
    check_drain("enable");
    $display("test_enable done, key_code=%0d", bus.key_code);
  endtask

  task automatic test_reset_mid();
    do_reset(16'h0200);          // key 9: col 2, row 1, sampled at cycle 5
    push_ev(1'b0, 9, 9);
    to_cycle(11);
    check_code("midrst_code_before", 9);
    check_held("midrst_held_before", 1'b1);
    check_drain("midrst_press");
    rst_n = 1'b0;
    #1 check_code("midrst_code", 0);
    check_held("midrst_held", 1'b0);
    n_checks++;
    if (bus.load !== 1'b0 || bus.key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pulses: key_valid=%b load=%b, required 0 0", bus.key_valid, bus.load);
    end
    keys = 16'h0004;             // key 2 on column 0: sampled at cycle 1 after release
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    push_ev(1'b0, 2, 5);
    to_cycle(7);
    check_drain("midrst_after");
    $display("test_reset_mid done, key_code=%0d", bus.key_code);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    keys     = '0;
    bus.en   = 1'b0;
    test_reset();
    test_press_release();
    test_press_bounce();
    test_release_bounce();
    test_two_keys();
    test_wrap();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
